// File: rtl/hr_pkg.sv
// Shared encoding and defaults for the heart-rate measurement sequencer.
package hr_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;

  // Default sizing: 15 ticks at 1 Hz, x4 scaling gives beats per minute
  localparam int CW_DEF          = 8;
  localparam int WIN_TICKS_DEF   = 15;
  localparam int SCALE_SHIFT_DEF = 2;

  // Saturation value for the default bpm width
  localparam logic [CW_DEF-1:0] BPM_SAT_DEF = {CW_DEF{1'b1}};

  // Window counter width: enough bits for 0..ticks-1, never less than one
  function automatic int win_w(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/hr_beat_sync.sv
// Brings the asynchronous sensor pulse into the clk domain and emits a
// single-cycle pulse for each rising edge. A long high level counts once.
module hr_beat_sync (
  input  logic clk,
  input  logic rst,
  input  logic beat_in,
  output logic beat_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next values of the synchronizer chain and the edge-history flop
  always_comb begin
    sync1_d = beat_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Pulse is decoded from registers only, so it is glitch-free
  assign beat_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/hr_measure_ctrl.sv
// Measurement sequencer: clear -> count -> capture -> compare, repeated until
// cls. Produces bpm from a fixed tick window and the over-threshold alarm.
module hr_measure_ctrl
  import hr_pkg::*;
#(
  parameter int WIN_TICKS   = WIN_TICKS_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cls,
  input  logic          tick,
  input  logic          beat_in,
  input  logic [CW-1:0] set_pulso,
  output logic          clear,
  output logic          en_count,
  output logic          en_cap,
  output logic [CW-1:0] bpm,
  output logic          alarm,
  output logic          busy
);

  localparam int WW = win_w(WIN_TICKS);
  localparam int BW = CW + SCALE_SHIFT;
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [BW-1:0] BPM_SAT_W = BW'(CNT_MAX);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] bpm_q, bpm_d;
  logic          alarm_q, alarm_d;
  logic          beat_pulse;
  logic [BW-1:0] bpm_wide;

  hr_beat_sync u_beat_sync (
    .clk        (clk),
    .rst        (rst),
    .beat_in    (beat_in),
    .beat_pulse (beat_pulse)
  );

  // Scale at full width so overflow is visible before saturation
  assign bpm_wide = BW'(beat_cnt_q) << SCALE_SHIFT;

  // Next-state, counter and result logic; cls overrides every state
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    win_cnt_d  = win_cnt_q;
    bpm_d      = bpm_q;
    alarm_d    = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        beat_cnt_d = '0;
        win_cnt_d  = '0;
        state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        if (beat_pulse && (beat_cnt_q != CNT_MAX)) beat_cnt_d = beat_cnt_q + 1'b1;
        if (tick) begin
          if (win_cnt_q == WIN_LAST) state_d = ST_CAPTURE;
          else                       win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        bpm_d   = (bpm_wide > BPM_SAT_W) ? CNT_MAX : bpm_wide[CW-1:0];
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        alarm_d = (bpm_q > set_pulso);
        state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cls) begin
      state_d = ST_IDLE;
      bpm_d   = '0;
      alarm_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      bpm_q      <= '0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      win_cnt_q  <= win_cnt_d;
      bpm_q      <= bpm_d;
      alarm_q    <= alarm_d;
    end
  end

  // Moore decodes of the state register
  assign clear    = (state_q == ST_CLEAR);
  assign en_count = (state_q == ST_COUNT);
  assign en_cap   = (state_q == ST_CAPTURE);
  assign busy     = (state_q != ST_IDLE);
  assign bpm      = bpm_q;
  assign alarm    = alarm_q;

endmodule

// File: doc/hr_measure_ctrl.md
# hr_measure_ctrl

Measurement sequencer for the heart-rate monitor. It runs the clear → count → capture → compare cycle that drives the beat counter and capture register, and computes beats-per-minute from a fixed tick window. It also raises the over-threshold alarm against `set_pulso`. It sits between the clock divider (which supplies `tick`), the pulse sensor input, and the display/alarm outputs of `tt_um_heart_rate`.

## Interface
- `WIN_TICKS`, default 15 — number of `tick` strobes per measurement window (15 s at 1 Hz).
- `SCALE_SHIFT`, default 2 — bpm = beats << SCALE_SHIFT (×4 for a 15 s window).
- `CW`, default 8 — width of beat count, bpm and threshold.
- `clk` in 1 — system clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `start` in 1 — synchronous level; begins measurement when sampled high in IDLE.
- `cls` in 1 — synchronous; abort and return to IDLE; priority over everything except `rst`.
- `tick` in 1 — single-cycle strobe from the divider, synchronous to `clk`.
- `beat_in` in 1 — asynchronous sensor pulse, any width ≥ 2 clk cycles.
- `set_pulso` in CW — alarm threshold in bpm.
- `clear` out 1 — high for exactly one cycle in CLEAR.
- `en_count` out 1 — high throughout COUNT.
- `en_cap` out 1 — high for exactly one cycle in CAPTURE.
- `bpm` out CW — last captured bpm.
- `alarm` out 1 — registered; 1 when the last `bpm` > `set_pulso`.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, COUNT, CAPTURE, CHECK (encoded in `hr_pkg`).
- IDLE: all strobes low. `start`=1 and `cls`=0 → CLEAR.
- CLEAR: `clear`=1; `beat_cnt`←0, `win_cnt`←0; → COUNT.
- COUNT: `en_count`=1.
  - Each synchronized beat rising edge increments `beat_cnt`, saturating at 2^CW−1.
  - Each `tick` increments `win_cnt`.
  - `tick` with `win_cnt`==WIN_TICKS−1 → CAPTURE.
- CAPTURE: `en_cap`=1; `bpm` ← min(`beat_cnt` << SCALE_SHIFT, 2^CW−1), computed at CW+SCALE_SHIFT width, then saturated.
- CHECK: `alarm` ← (`bpm` > `set_pulso`), strict unsigned compare using `set_pulso` as sampled in this cycle; → CLEAR. Measurement repeats continuously until `cls`.
- `cls`=1 in any state → IDLE on the next edge; `alarm`←0 and `bpm`←0 on the same edge. When `start` and `cls` are both high in IDLE, the block stays in IDLE.
- `start` outside IDLE is ignored.
- `tick` outside COUNT is ignored; the window does not begin until COUNT.
- Beat edges arriving outside COUNT are discarded (CLEAR zeroes the count anyway).
- Beat and final `tick` in the same cycle: the beat is counted before capture.
- A long `beat_in` high counts once; only rising edges count.
- `rst` asserted mid-operation: immediate IDLE, all outputs 0, counters 0.

## Timing
- Reset values: `clear`=`en_count`=`en_cap`=`busy`=`alarm`=0, `bpm`=0, state IDLE.
- Strobes and `busy` are Moore decodes of the state register; no combinational path from inputs to outputs.
- `start` sampled at edge k → CLEAR during cycle k..k+1 → COUNT from edge k+1.
- Beat path: 2-FF synchronizer plus edge register. `beat_cnt` increments on the 3rd clk edge that samples `beat_in` high.
- Final `tick` at edge t → CAPTURE in cycle t; `bpm` valid after edge t+1; `alarm` valid after edge t+2; CLEAR in cycle t+2; next COUNT from edge t+3.
- `bpm` and `alarm` hold their values through the following window until the next CAPTURE/CHECK.

## Structure
- `hr_pkg`: state encoding localparams, default CW / WIN_TICKS / SCALE_SHIFT, bpm saturation constant.
- Sub-module `hr_beat_sync`: 2-FF synchronizer plus rising-edge detector; outputs a one-cycle `beat_pulse`; async active-high reset.
- `win_cnt` width: $clog2(WIN_TICKS) bits, minimum 1.

## Test plan
- Reset: assert `rst` mid-COUNT → all outputs 0 the same cycle, state IDLE; release, idle 10 cycles → outputs remain 0.
- WIN_TICKS=4, SHIFT=2, `set_pulso`=100: `start`, 18 beats in window → one `en_cap` pulse, `bpm`=72, `alarm`=0, CLEAR follows two cycles after CAPTURE.
- `set_pulso`=16, 5 beats → `bpm`=20, `alarm`=1 after CHECK; next window with 3 beats → `bpm`=12, `alarm`=0.
- 70 beats in one window → `bpm`=255 (saturated); 300 beats → `beat_cnt` saturates, `bpm`=255.
- `cls` during COUNT → IDLE next edge, `bpm`=0, `alarm`=0, `busy`=0; `start`+`cls` together in IDLE → stays IDLE.
- Beat rising in the same cycle as the final `tick` is counted; `beat_in` held high 50 cycles counts 1; beats during IDLE/CLEAR are not counted.
